// File: rtl/route_demux6_pkg.sv
// Shared definitions for the 1:6 route demultiplexer: channel indices,
// FSM state type and a one-hot helper.
package route_demux6_pkg;

    localparam int NUM_CH = 6;

    localparam logic [2:0] CH_A = 3'd0;
    localparam logic [2:0] CH_B = 3'd1;
    localparam logic [2:0] CH_C = 3'd2;
    localparam logic [2:0] CH_D = 3'd3;
    localparam logic [2:0] CH_E = 3'd4;
    localparam logic [2:0] CH_F = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } route_state_t;

    // Channel index to one-hot valid vector; indices 6/7 never occur here.
    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [2:0] ch);
        logic [NUM_CH-1:0] r;
        r = '0;
        r[ch] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/route_demux6_sel_decode.sv
// Priority decode of the five route selects into a destination channel index.
module route_demux6_sel_decode
    import route_demux6_pkg::*;
(
    input  logic       sel1,
    input  logic       sel2,
    input  logic       sel3,
    input  logic       sel4,
    input  logic       sel5,
    output logic [2:0] ch
);

    // sel1 has top priority; sel3 only splits the sel2 case between b and c.
    always_comb begin
        ch = CH_F;
        if (sel1)      ch = CH_A;
        else if (sel2) ch = sel3 ? CH_B : CH_C;
        else if (sel4) ch = CH_D;
        else if (sel5) ch = CH_E;
    end

endmodule

// File: rtl/route_demux6.sv
// 1:6 registered route demultiplexer with valid/ready on both sides and a
// per-channel delivery counter with combinational readback.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. din_valid/din/selects are sampled only on accept. dout_valid is one-hot
// toward the destination; only dout_ready[dest] is observed. din_ready passes
// through the consumer's ready while holding, so back-to-back words stream at
// one per cycle with no bubble.
module route_demux6
    import route_demux6_pkg::*;
#(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      din,
    input  logic              sel1,
    input  logic              sel2,
    input  logic              sel3,
    input  logic              sel4,
    input  logic              sel5,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [W-1:0]      dout,
    output logic [NUM_CH-1:0] dout_valid,
    input  logic [NUM_CH-1:0] dout_ready,
    input  logic              clr_cnt,
    input  logic [2:0]        cnt_sel,
    output logic [CW-1:0]     cnt_out,
    output route_state_t      state_dbg
);

    route_state_t  state;
    logic [2:0]    dest;
    logic [2:0]    dec_ch;
    logic          accept;
    logic          deliver;
    logic [CW-1:0] cnt [NUM_CH];

    route_demux6_sel_decode u_dec (
        .sel1 (sel1),
        .sel2 (sel2),
        .sel3 (sel3),
        .sel4 (sel4),
        .sel5 (sel5),
        .ch   (dec_ch)
    );

    assign deliver   = (state == ST_HOLD) && dout_ready[dest];
    assign din_ready = (state == ST_IDLE) || deliver;
    assign accept    = din_valid && din_ready;
    assign state_dbg = state;

    // FSM with registered data, destination and one-hot valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            dout       <= '0;
            dest       <= CH_A;
            dout_valid <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        dout       <= din;
                        dest       <= dec_ch;
                        dout_valid <= ch_onehot(dec_ch);
                        state      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (deliver) begin
                        if (accept) begin
                            dout       <= din;
                            dest       <= dec_ch;
                            dout_valid <= ch_onehot(dec_ch);
                        end else begin
                            dout_valid <= '0;
                            state      <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    dout_valid <= '0;
                end
            endcase
        end
    end

    // Delivery counters: clear beats increment, increments wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) cnt[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (clr_cnt)
                    cnt[k] <= '0;
                else if (deliver && (dest == 3'(k)))
                    cnt[k] <= cnt[k] + 1'b1;
            end
        end
    end

    // Readback mux; out-of-range indices read zero.
    always_comb begin
        cnt_out = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (cnt_sel == 3'(k)) cnt_out = cnt[k];
        end
    end

endmodule

// File: tb/tb_route_demux6.sv
// Scoreboard bench for route_demux6: driver pushes {dest,data} on accept,
// negedge monitor checks the presented word and pops on delivery.
module tb_route_demux6;
    import route_demux6_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din = '0;
    logic       sel1 = 1'b0, sel2 = 1'b0, sel3 = 1'b0, sel4 = 1'b0, sel5 = 1'b0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic [3:0] dout;
    logic [5:0] dout_valid;
    logic [5:0] dout_ready = '0;
    logic       clr_cnt = 1'b0;
    logic [2:0] cnt_sel = '0;
    logic [7:0] cnt_out;
    route_state_t state_dbg;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;

    logic [6:0] exp_q[$];
    int         cnt_model[6];
    bit         rand_rdy = 1'b0;
    logic [5:0] ready_fixed = '0;

    route_demux6 #(.W(4), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din),
        .sel1(sel1), .sel2(sel2), .sel3(sel3), .sel4(sel4), .sel5(sel5),
        .din_valid(din_valid), .din_ready(din_ready),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .clr_cnt(clr_cnt), .cnt_sel(cnt_sel), .cnt_out(cnt_out),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // consumer ready: fixed pattern or random per cycle
    always @(posedge clk) begin
        #1;
        dout_ready = rand_rdy ? 6'($urandom) : ready_fixed;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // routing rule straight from the select priority table
    function automatic int ref_dest(input logic [4:0] s);
        if (s[0]) return 0;
        if (s[1] && s[2]) return 1;
        if (s[1]) return 2;
        if (s[3]) return 3;
        if (s[4]) return 4;
        return 5;
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() == 0) begin
                chk("idle_valid", 32'(dout_valid), 32'd0);
            end else begin
                int ch;
                logic [3:0] d;
                ch = int'(exp_q[0][6:4]);
                d  = exp_q[0][3:0];
                chk("valid_onehot", 32'(dout_valid), 32'(1) << ch);
                chk("dout_data", 32'(dout), 32'(d));
                if (dout_ready[ch]) begin
                    void'(exp_q.pop_front());
                    cnt_model[ch] = (cnt_model[ch] + 1) % 256;
                end
            end
            if (clr_cnt) foreach (cnt_model[k]) cnt_model[k] = 0;
        end
    end

    // driver: offer one word, push expectation on the accepting edge
    task automatic send(input logic [3:0] d, input logic [4:0] s);
        bit done = 0;
        int waited = 0;
        din = d;
        {sel5, sel4, sel3, sel2, sel1} = s;
        din_valid = 1'b1;
        while (!done && waited < 200) begin
            logic rdy;
            @(negedge clk);
            rdy = din_ready;
            @(posedge clk);
            if (rdy) begin
                exp_q.push_back({3'(ref_dest(s)), d});
                done = 1;
            end
            waited++;
        end
        #1;
        if (!done) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
        end
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic check_cnt(input string name, input int ch);
        @(posedge clk);
        #2;
        cnt_sel = 3'(ch);
        #1;
        chk(name, 32'(cnt_out), (ch < 6) ? 32'(cnt_model[ch]) : 32'd0);
    endtask

    task automatic clear_counters();
        @(posedge clk); #1;
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
    endtask

    initial begin
        logic [4:0] dec_tab[6];
        int t0;
        dec_tab[0] = 5'b00001; dec_tab[1] = 5'b00110; dec_tab[2] = 5'b00010;
        dec_tab[3] = 5'b01000; dec_tab[4] = 5'b10000; dec_tab[5] = 5'b00000;
        foreach (cnt_model[k]) cnt_model[k] = 0;

        // reset values
        repeat (3) @(posedge clk);
        #2;
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_valid", 32'(dout_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            cnt_sel = 3'(k);
            #1;
            chk("rst_cnt", 32'(cnt_out), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_din_ready", 32'(din_ready), 32'd1);

        // directed decode, all consumers ready
        ready_fixed = 6'h3f;
        idle(2);
        for (int i = 0; i < 6; i++) begin
            send(4'h5, dec_tab[i]);
            idle(2);
        end
        drain();
        for (int k = 0; k < 6; k++) check_cnt("decode_cnt", k);

        // backpressure on channel d
        clear_counters();
        ready_fixed = '0;
        idle(2);
        send(4'hA, 5'b01000);
        din_valid = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
            chk("bp_din_ready", 32'(din_ready), 32'd0);
        end
        ready_fixed = 6'b001000;
        drain();
        check_cnt("bp_cnt3", 3);
        chk("bp_cnt3_is_one", 32'(cnt_model[3]), 32'd1);

        // streaming eight words to channel f
        clear_counters();
        ready_fixed = 6'h3f;
        idle(2);
        t0 = cyc;
        for (int i = 0; i < 8; i++) send(4'(i), 5'b00000);
        chk("stream_cycles", 32'(cyc - t0), 32'd8);
        idle(1);
        drain();
        check_cnt("stream_cnt5", 5);

        // random traffic with random consumer readiness
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send(4'($urandom), 5'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        din_valid = 1'b0;
        rand_rdy = 1'b0;
        ready_fixed = 6'h3f;
        drain();
        for (int k = 0; k < 8; k++) check_cnt("rand_cnt", k);

        // 256 deliveries to channel a wrap the counter to zero
        clear_counters();
        for (int i = 0; i < 256; i++) send(4'($urandom), 5'b00001);
        idle(1);
        drain();
        check_cnt("wrap_cnt0", 0);

        // a few more, then clear in the same cycle as a delivery
        for (int i = 0; i < 3; i++) send(4'h1, 5'b00001);
        idle(1);
        drain();
        check_cnt("pre_clr_cnt0", 0);
        ready_fixed = '0;
        idle(2);
        send(4'h7, 5'b00001);
        din_valid = 1'b0;
        @(posedge clk); #1;
        ready_fixed = 6'h3f;
        clr_cnt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        drain();
        check_cnt("clr_deliver_cnt0", 0);

        // reset in the middle of a held word
        ready_fixed = '0;
        idle(2);
        send(4'h9, 5'b00010);
        din_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        foreach (cnt_model[k]) cnt_model[k] = 0;
        #1;
        chk("midrst_valid", 32'(dout_valid), 32'd0);
        chk("midrst_dout", 32'(dout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ready_fixed = 6'h3f;
        idle(4);
        for (int k = 0; k < 6; k++) check_cnt("midrst_cnt", k);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
